quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 45 ++++
 rtl/quad_decoder_if.sv | 27 ++
 rtl/quad_filter.sv | 75 +++++++
 rtl/quad_decoder.sv | 109 ++++++++++
 tb/tb_quad_decoder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
// phase_t  : filtered {a,b} phase, a 2-bit Gray state
// state_e  : decoder FSM state (StInit = no valid reference, StTrack = counting)
// dir_e    : classification of a phase change
// decode_dir: pure direction decode from previous and new phase
package quad_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic {StInit, StTrack} state_e;

  typedef enum logic [1:0] {DirNone, DirFwd, DirRev, DirIllegal} dir_e;

  // Forward order: 00 -> 01 -> 11 -> 10 -> 00
  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  function automatic phase_t fwd_next(input phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

  function automatic dir_e decode_dir(input phase_t prev, input phase_t next);
    dir_e d;
    if (prev == next) begin
      d = DirNone;
    end else if (next == fwd_next(prev)) begin
      d = DirFwd;
    end else if (prev == fwd_next(next)) begin
      d = DirRev;
    end else begin
      d = DirIllegal;
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Bus between the quadrature decoder and its user.
// en_, clr_ : active-low count enable and synchronous clear
// qa, qb    : raw quadrature phases (asynchronous to clk)
// step, up, count, err : decoder results
// master drives the controls/phases, slave is the decoder.
interface quad_decoder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en_;
  logic             clr_;
  logic             qa;
  logic             qb;
  logic             step;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             err;

  modport master (
    output en_, clr_, qa, qb,
    input  step, up, count, err
  );

  modport slave (
    input  en_, clr_, qa, qb,
    output step, up, count, err
  );
endinterface

// File: rtl/quad_filter.sv
// Two-flop synchronizer plus stability filter for one quadrature phase.
// clk, rst_ : clock and asynchronous active-low reset
// din       : raw asynchronous input
// level     : accepted level (valid in the same cycle the filter accepts it)
// valid     : an initial level has been established since reset
module quad_filter #(
  parameter int unsigned FILT = 2
) (
  input  logic clk,
  input  logic rst_,
  input  logic din,
  output logic level,
  output logic valid
);

  localparam logic [3:0] CntMax = 4'(FILT - 1);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       level_q, level_d;
  logic       valid_q, valid_d;
  logic [3:0] cnt_q, cnt_d;
  logic       smp;

  assign smp = sync_q[1];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_q  <= '0;
      fill_q  <= '0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], din};
      fill_q  <= {fill_q[0], 1'b1};
      level_q <= level_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accepted level is presented combinationally on the sample that
  // completes the run, so the decoder reacts on that same edge.
  always_comb begin
    level_d = level_q;
    valid_d = valid_q;
    cnt_d   = '0;
    if (!valid_q) begin
      // fill_q[1] marks that smp holds a real sample, not a reset value.
      // Until valid, level_q just follows the samples and the run length
      // of identical ones is counted.
      if (fill_q[1]) begin
        level_d = smp;
        if (cnt_q != '0 && smp != level_q) begin
          cnt_d = 4'd1;
        end else if (cnt_q == CntMax) begin
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end else if (smp != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = smp;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign level = level_d;
  assign valid = valid_d;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters qa/qb, tracks the Gray phase and maintains a
// modular position count.
// clk, rst_ : clock and asynchronous active-low reset
// bus       : quad_decoder_if slave (en_, clr_, qa, qb in; step, up, count, err out)
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FILT  = 2
) (
  input  logic           clk,
  input  logic           rst_,
  quad_decoder_if.slave  bus
);

  logic       a_lvl, a_vld;
  logic       b_lvl, b_vld;
  phase_t     cur_ph;
  dir_e       dir;

  state_e           state_q;
  phase_t           ref_q;
  logic [WIDTH-1:0] count_q;
  logic             up_q;
  logic             step_q;
  logic             err_q;

  quad_filter #(
    .FILT (FILT)
  ) u_filt_a (
    .clk   (clk),
    .rst_  (rst_),
    .din   (bus.qa),
    .level (a_lvl),
    .valid (a_vld)
  );

  quad_filter #(
    .FILT (FILT)
  ) u_filt_b (
    .clk   (clk),
    .rst_  (rst_),
    .din   (bus.qb),
    .level (b_lvl),
    .valid (b_vld)
  );

  assign cur_ph = {a_lvl, b_lvl};

  always_comb begin
    dir = decode_dir(ref_q, cur_ph);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StInit;
      ref_q   <= PH_00;
      count_q <= '0;
      up_q    <= 1'b1;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        StInit: begin
          if (a_vld && b_vld) begin
            ref_q   <= cur_ph;
            state_q <= StTrack;
          end
        end
        StTrack: begin
          // Reference always follows the filtered phase, even when counting
          // is disabled, cleared or the change is illegal.
          ref_q <= cur_ph;
          case (dir)
            DirIllegal: err_q <= 1'b1;
            DirFwd: begin
              if (!bus.en_ && bus.clr_) begin
                count_q <= count_q + WIDTH'(1);
                up_q    <= 1'b1;
                step_q  <= 1'b1;
              end
            end
            DirRev: begin
              if (!bus.en_ && bus.clr_) begin
                count_q <= count_q - WIDTH'(1);
                up_q    <= 1'b0;
                step_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: state_q <= StInit;
      endcase
      // Clear wins over any same-cycle transition or error.
      if (!bus.clr_) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.step  = step_q;
  assign bus.up    = up_q;
  assign bus.count = count_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=5, FILT=2).
module tb_quad_decoder;

  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst_;

  quad_decoder_if #(.WIDTH(W)) bus ();

  quad_decoder #(
    .WIDTH (W),
    .FILT  (2)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_step = 0;
  int unsigned snap;
  logic [1:0]  ph;

  always @(negedge clk) begin
    if (bus.step === 1'b1) n_step++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] p);
    case (p)
      2'b01:   return 2'b00;
      2'b11:   return 2'b01;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic drive(input logic [1:0] p);
    @(negedge clk);
    ph     = p;
    bus.qa = p[1];
    bus.qb = p[0];
    tick(6);
  endtask

  task automatic step_fwd(input int n);
    repeat (n) drive(fwd(ph));
  endtask

  initial begin
    rst_     = 1'b0;
    ph       = 2'b00;
    bus.qa   = 1'b0;
    bus.qb   = 1'b0;
    bus.en_  = 1'b0;
    bus.clr_ = 1'b1;
    tick(2);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_step",  32'(bus.step),  32'd0);
    check("rst_up",    32'(bus.up),    32'd1);
    check("rst_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    tick(6);
    check("init_no_count", 32'(bus.count), 32'd0);

    // 8 forward steps from 00
    snap = n_step;
    step_fwd(8);
    check("fwd8_count", 32'(bus.count), 32'd8);
    check("fwd8_up",    32'(bus.up),    32'd1);
    check("fwd8_steps", n_step - snap,  32'd8);
    check("fwd8_err",   32'(bus.err),   32'd0);

    // wrap both ways
    step_fwd(23);
    check("to31_count", 32'(bus.count), 32'd31);
    step_fwd(1);
    check("wrap_up_count", 32'(bus.count), 32'd0);
    drive(rev(ph));
    check("wrap_dn_count", 32'(bus.count), 32'd31);
    check("wrap_dn_up",    32'(bus.up),    32'd0);

    // one-cycle glitch on qa (currently 1)
    snap = n_step;
    @(negedge clk);
    bus.qa = 1'b0;
    @(negedge clk);
    bus.qa = 1'b1;
    tick(6);
    check("glitch_count", 32'(bus.count), 32'd31);
    check("glitch_steps", n_step - snap,  32'd0);
    check("glitch_err",   32'(bus.err),   32'd0);

    // latency: 10 -> 00 forward, first sampled at edge k, visible after k+3
    @(negedge clk);
    bus.qa = 1'b0;
    ph     = 2'b00;
    tick(3);
    check("lat_k2_count", 32'(bus.count), 32'd31);
    tick(1);
    check("lat_k3_count", 32'(bus.count), 32'd0);
    check("lat_k3_step",  32'(bus.step),  32'd1);
    check("lat_k3_up",    32'(bus.up),    32'd1);
    tick(4);

    // illegal jump 01 -> 10
    step_fwd(1);
    check("pre_jump_count", 32'(bus.count), 32'd1);
    snap = n_step;
    drive(2'b10);
    check("jump_err",   32'(bus.err),   32'd1);
    check("jump_count", 32'(bus.count), 32'd1);
    check("jump_steps", n_step - snap,  32'd0);
    step_fwd(1);
    check("sticky_err",  32'(bus.err),   32'd1);
    check("post_jump_count", 32'(bus.count), 32'd2);

    // one-cycle clear
    @(negedge clk);
    bus.clr_ = 1'b0;
    tick(1);
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    bus.clr_ = 1'b1;
    tick(4);
    step_fwd(1);
    check("after_clr_count", 32'(bus.count), 32'd1);

    // disabled counting, reference still tracks
    bus.en_ = 1'b1;
    snap = n_step;
    step_fwd(4);
    check("dis_count", 32'(bus.count), 32'd1);
    check("dis_steps", n_step - snap,  32'd0);
    bus.en_ = 1'b0;
    step_fwd(1);
    check("reen_count", 32'(bus.count), 32'd2);
    drive(rev(ph));
    check("rev_count", 32'(bus.count), 32'd1);
    check("rev_up",    32'(bus.up),    32'd0);

    // asynchronous reset mid-operation (phase stays 01)
    @(posedge clk);
    #3;
    rst_ = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_up",    32'(bus.up),    32'd1);
    check("arst_step",  32'(bus.step),  32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    snap = n_step;
    tick(8);
    check("post_rst_steps", n_step - snap,  32'd0);
    check("post_rst_count", 32'(bus.count), 32'd0);
    step_fwd(1);
    check("post_rst_fwd", 32'(bus.count), 32'd1);
    check("post_rst_up",  32'(bus.up),    32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
